smi_line_rx: RTL and testbench

SMI_LINE_RX -- requirements
Module: smi_line_rx

---
 rtl/smi_line_rx.sv | 164 ++++++++++++++++
 tb/tb_smi_line_rx.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/smi_line_rx.sv
// SMI line receiver: synchronizes Pi SMI writes into a ping-pong pair of line banks, display bank readable by address.
// Latency: write visible SYNC_STAGES+1 clk after nwe rises; rd_data one clk after rd_addr; line_ready one clk after swap.
// Backpressure: none; bytes arriving with the fill bank full are dropped. Stats flags built only with SMI_RX_STATS_EN defined.
module smi_line_rx #(
   parameter int LINE_BYTES  = 192,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       global_rst_n,
   input  logic       line_sync,
   input  logic       smi_nwe_pi,
   input  logic [7:0] smi_data_pi,
   input  logic [7:0] rd_addr,
   output logic [7:0] rd_data,
   output logic       line_ready,
   output logic [7:0] wr_count,
   input  logic       stat_clr,
   output logic       overrun,
   output logic       short_line
);

   typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

   localparam logic [7:0] LB = 8'(LINE_BYTES);

   state_t                        state, state_nxt;
   logic                          bank_sel;
   logic [SYNC_STAGES-1:0]        nwe_sync;
   logic [SYNC_STAGES-1:0][7:0]   data_sync;
   logic                          nwe_prev;
   logic                          wr_det;
   logic [7:0]                    wr_byte;
   logic                          swap;
   logic                          accept;
   logic                          wr_bank;
   logic [7:0]                    wr_addr;
   logic [7:0]                    wr_count_nxt;

   // Line storage; bank index == bank_sel is the fill bank, the other is displayed.
   logic [7:0] bank0 [LINE_BYTES];
   logic [7:0] bank1 [LINE_BYTES];

   // Strobe and data share the same synchronizer depth so the byte lines up with the edge.
   always_ff @(posedge clk or negedge global_rst_n) begin
      if (!global_rst_n) begin
         nwe_sync  <= '1;
         data_sync <= '0;
         nwe_prev  <= 1'b1;
      end else begin
         nwe_sync  <= {nwe_sync[SYNC_STAGES-2:0], smi_nwe_pi};
         data_sync <= {data_sync[SYNC_STAGES-2:0], smi_data_pi};
         nwe_prev  <= nwe_sync[SYNC_STAGES-1];
      end
   end

   assign wr_det  = nwe_sync[SYNC_STAGES-1] & ~nwe_prev;
   assign wr_byte = data_sync[SYNC_STAGES-1];

   // Next-state and fill control; a line_sync swap takes priority and a coincident byte lands at address 0 of the new bank.
   always_comb begin
      state_nxt    = state;
      swap         = 1'b0;
      accept       = 1'b0;
      wr_bank      = bank_sel;
      wr_addr      = wr_count;
      wr_count_nxt = wr_count;
      case (state)
         IDLE: begin
            if (line_sync) begin
               state_nxt = FILL;
            end
         end
         FILL, FULL: begin
            if (line_sync) begin
               swap         = 1'b1;
               wr_bank      = ~bank_sel;
               wr_addr      = 8'd0;
               accept       = wr_det;
               wr_count_nxt = wr_det ? 8'd1 : 8'd0;
            end else if (state == FILL) begin
               accept = wr_det;
               if (wr_det) begin
                  wr_count_nxt = wr_count + 8'd1;
               end
            end
            state_nxt = (wr_count_nxt == LB) ? FULL : FILL;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, bank selection, fill counter and the completed-line pulse.
   always_ff @(posedge clk or negedge global_rst_n) begin
      if (!global_rst_n) begin
         state      <= IDLE;
         bank_sel   <= 1'b0;
         wr_count   <= 8'd0;
         line_ready <= 1'b0;
      end else begin
         state      <= state_nxt;
         wr_count   <= wr_count_nxt;
         line_ready <= swap && (state == FULL);
         if (swap) begin
            bank_sel <= ~bank_sel;
         end
      end
   end

   // Bank writes; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         if (wr_bank) begin
            bank1[wr_addr] <= wr_byte;
         end else begin
            bank0[wr_addr] <= wr_byte;
         end
      end
   end

   // Registered display read; the registered bank_sel means a swap only affects the following read.
   always_ff @(posedge clk or negedge global_rst_n) begin
      if (!global_rst_n) begin
         rd_data <= 8'd0;
      end else if (rd_addr < LB) begin
         rd_data <= bank_sel ? bank0[rd_addr] : bank1[rd_addr];
      end else begin
         rd_data <= 8'd0;
      end
   end

`ifdef SMI_RX_STATS_EN
   logic ovr_set;
   logic short_set;

   assign ovr_set   = (state == FULL) && wr_det && !line_sync;
   assign short_set = (state == FILL) && line_sync;

   // Sticky flags; a set event in the same cycle wins over stat_clr.
   always_ff @(posedge clk or negedge global_rst_n) begin
      if (!global_rst_n) begin
         overrun    <= 1'b0;
         short_line <= 1'b0;
      end else begin
         if (ovr_set) begin
            overrun <= 1'b1;
         end else if (stat_clr) begin
            overrun <= 1'b0;
         end
         if (short_set) begin
            short_line <= 1'b1;
         end else if (stat_clr) begin
            short_line <= 1'b0;
         end
      end
   end
`else
   logic unused_stat_clr;

   assign unused_stat_clr = stat_clr;
   assign overrun         = 1'b0;
   assign short_line      = 1'b0;
`endif

endmodule

// File: tb/tb_smi_line_rx.sv
// Bench for smi_line_rx: directed SMI writes and line_sync pulses, expectations queued and checked by a monitor.
// Reads are checked one clk after the request; status expectations are checked at the following falling edge.
// Flag expectations follow SMI_RX_STATS_EN so the same bench covers both builds.
module tb_smi_line_rx;

   localparam int LB = 192;
   localparam int SY = 2;
`ifdef SMI_RX_STATS_EN
   localparam logic STATS = 1'b1;
`else
   localparam logic STATS = 1'b0;
`endif

   localparam logic [2:0] K_WRC   = 3'd1;
   localparam logic [2:0] K_OVR   = 3'd2;
   localparam logic [2:0] K_SHORT = 3'd3;
   localparam logic [2:0] K_LR    = 3'd4;
   localparam logic [2:0] K_LRCNT = 3'd5;
   localparam logic [2:0] K_RDNOW = 3'd6;

   typedef struct packed {
      logic [2:0]  kind;
      logic [7:0]  addr;
      logic [15:0] exp;
   } chk_t;

   logic       clk = 1'b0;
   logic       global_rst_n;
   logic       line_sync;
   logic       smi_nwe_pi;
   logic [7:0] smi_data_pi;
   logic [7:0] rd_addr;
   logic [7:0] rd_data;
   logic       line_ready;
   logic [7:0] wr_count;
   logic       stat_clr;
   logic       overrun;
   logic       short_line;

   chk_t        rd_q[$];
   chk_t        st_q[$];
   chk_t        ent;
   logic [15:0] act;
   logic        rd_req = 1'b0;
   logic        rd_req_q = 1'b0;
   logic        done = 1'b0;
   int          checks = 0;
   int          errors = 0;
   int          lr_count = 0;
   int          cyc = 0;
   int          exp_lr = 0;

   smi_line_rx #(.LINE_BYTES(LB), .SYNC_STAGES(SY)) dut (
      .clk         (clk),
      .global_rst_n(global_rst_n),
      .line_sync   (line_sync),
      .smi_nwe_pi  (smi_nwe_pi),
      .smi_data_pi (smi_data_pi),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .line_ready  (line_ready),
      .wr_count    (wr_count),
      .stat_clr    (stat_clr),
      .overrun     (overrun),
      .short_line  (short_line)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rd_req_q <= rd_req;

   function automatic string kname(input logic [2:0] k);
      case (k)
         K_WRC:   return "wr_count";
         K_OVR:   return "overrun";
         K_SHORT: return "short_line";
         K_LR:    return "line_ready";
         K_LRCNT: return "line_ready_pulses";
         K_RDNOW: return "rd_data_now";
         default: return "unknown";
      endcase
   endfunction

   // Monitor: counts line_ready pulses, pops expectations and compares them against the DUT.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (line_ready) lr_count = lr_count + 1;
      if (rd_req_q) begin
         checks = checks + 1;
         if (rd_q.size() == 0) begin
            errors = errors + 1;
            $display("FAIL rd_unexpected got %h want none", rd_data);
         end else begin
            ent = rd_q.pop_front();
            if (rd_data !== ent.exp[7:0]) begin
               errors = errors + 1;
               $display("FAIL rd_data addr %0d got %h want %h", ent.addr, rd_data, ent.exp[7:0]);
            end
         end
      end
      while (st_q.size() > 0) begin
         ent = st_q.pop_front();
         case (ent.kind)
            K_WRC:   act = {8'd0, wr_count};
            K_OVR:   act = {15'd0, overrun};
            K_SHORT: act = {15'd0, short_line};
            K_LR:    act = {15'd0, line_ready};
            K_LRCNT: act = 16'(lr_count);
            K_RDNOW: act = {8'd0, rd_data};
            default: act = 16'hFFFF;
         endcase
         checks = checks + 1;
         if (act !== ent.exp) begin
            errors = errors + 1;
            $display("FAIL %s got %0h want %0h", kname(ent.kind), act, ent.exp);
         end
      end
      if (done || cyc > 60000) begin
         if (!done) begin
            errors = errors + 1;
            $display("FAIL timeout got %0d cycles want done", cyc);
         end
         if (rd_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL rd_pending got %0d want 0", rd_q.size());
         end
         $display("CHECKS %0d ERRORS %0d", checks, errors);
         $finish;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_st(input logic [2:0] k, input int v);
      st_q.push_back('{kind: k, addr: 8'd0, exp: 16'(v)});
   endtask

   task automatic rd(input logic [7:0] a, input logic [7:0] v);
      rd_addr = a;
      rd_req  = 1'b1;
      rd_q.push_back('{kind: 3'd0, addr: a, exp: {8'd0, v}});
      tick();
      rd_req = 1'b0;
   endtask

   task automatic smi_write(input logic [7:0] b);
      smi_data_pi = b;
      smi_nwe_pi  = 1'b0;
      repeat (SY + 2) tick();
      smi_nwe_pi = 1'b1;
      repeat (SY + 2) tick();
   endtask

   task automatic pulse_sync();
      line_sync = 1'b1;
      tick();
      line_sync = 1'b0;
      tick();
      tick();
   endtask

   task automatic pulse_clr();
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      tick();
   endtask

   // Write whose synchronized rising edge lands in the same cycle as line_sync.
   task automatic coincident_write(input logic [7:0] b);
      smi_data_pi = b;
      smi_nwe_pi  = 1'b0;
      repeat (SY + 2) tick();
      smi_nwe_pi = 1'b1;
      repeat (SY) tick();
      line_sync = 1'b1;
      tick();
      line_sync = 1'b0;
      repeat (SY + 2) tick();
   endtask

   // Directed stimulus.
   initial begin
      global_rst_n = 1'b0;
      line_sync    = 1'b0;
      smi_nwe_pi   = 1'b1;
      smi_data_pi  = 8'd0;
      rd_addr      = 8'd0;
      stat_clr     = 1'b0;
      repeat (3) tick();
      expect_st(K_WRC, 0);
      expect_st(K_OVR, 0);
      expect_st(K_SHORT, 0);
      expect_st(K_LR, 0);
      expect_st(K_RDNOW, 0);
      tick();
      global_rst_n = 1'b1;
      tick();

      // IDLE: writes ignored, first line_sync opens the fill without a swap
      for (int i = 0; i < 3; i++) smi_write(8'(8'hE0 + i));
      expect_st(K_WRC, 0);
      expect_st(K_OVR, 0);
      pulse_sync();
      expect_st(K_LRCNT, exp_lr);
      expect_st(K_WRC, 0);
      expect_st(K_SHORT, 0);

      // Complete line 0x01..0xC0
      for (int i = 0; i < LB; i++) smi_write(8'(i + 1));
      expect_st(K_WRC, LB);
      pulse_sync();
      exp_lr = exp_lr + 1;
      expect_st(K_LRCNT, exp_lr);
      expect_st(K_WRC, 0);
      expect_st(K_SHORT, 0);
      rd(8'd0, 8'h01);
      rd(8'd191, 8'hC0);
      rd(8'd95, 8'h60);
      rd(8'd192, 8'h00);
      rd(8'd255, 8'h00);

      // Overrun: 193 writes, last one dropped
      for (int i = 0; i < LB; i++) smi_write(8'(8'hFF - i));
      smi_write(8'hAA);
      expect_st(K_WRC, LB);
      expect_st(K_OVR, STATS);
      pulse_sync();
      exp_lr = exp_lr + 1;
      expect_st(K_LRCNT, exp_lr);
      expect_st(K_WRC, 0);
      rd(8'd0, 8'hFF);
      rd(8'd1, 8'hFE);
      rd(8'd191, 8'h40);
      rd(8'd192, 8'h00);
      pulse_clr();
      expect_st(K_OVR, 0);

      // Short line: 100 bytes, stale tail from the first line remains
      for (int i = 0; i < 100; i++) smi_write(8'(8'h20 + i));
      expect_st(K_WRC, 100);
      pulse_sync();
      expect_st(K_LRCNT, exp_lr);
      expect_st(K_SHORT, STATS);
      expect_st(K_WRC, 0);
      rd(8'd0, 8'h20);
      rd(8'd99, 8'h83);
      rd(8'd150, 8'h97);
      pulse_clr();
      expect_st(K_SHORT, 0);

      // Write coincident with line_sync
      for (int i = 0; i < 5; i++) smi_write(8'(8'h51 + i));
      coincident_write(8'h99);
      expect_st(K_WRC, 1);
      expect_st(K_LRCNT, exp_lr);
      expect_st(K_SHORT, STATS);
      rd(8'd0, 8'h51);
      rd(8'd4, 8'h55);
      rd(8'd5, 8'hFA);
      pulse_sync();
      expect_st(K_WRC, 0);
      expect_st(K_LRCNT, exp_lr);
      rd(8'd0, 8'h99);
      rd(8'd1, 8'h21);
      rd(8'd100, 8'h65);

      // Reset mid-line forces outputs immediately
      rd_addr = 8'd0;
      for (int i = 0; i < 50; i++) smi_write(8'(8'h70 + i));
      expect_st(K_WRC, 50);
      expect_st(K_RDNOW, 8'h99);
      expect_st(K_SHORT, STATS);
      tick();
      @(posedge clk);
      #2;
      global_rst_n = 1'b0;
      expect_st(K_WRC, 0);
      expect_st(K_RDNOW, 0);
      expect_st(K_SHORT, 0);
      expect_st(K_OVR, 0);
      expect_st(K_LR, 0);
      tick();
      tick();
      global_rst_n = 1'b1;
      tick();

      // After reset: ignore until line_sync, which does not swap
      smi_write(8'h33);
      smi_write(8'h34);
      expect_st(K_WRC, 0);
      pulse_sync();
      expect_st(K_LRCNT, exp_lr);
      expect_st(K_WRC, 0);
      smi_write(8'h11);
      expect_st(K_WRC, 1);

      repeat (4) tick();
      done = 1'b1;
   end

endmodule
